add4_sequencer: RTL and testbench
=================================

// Module: add4_sequencer
// PURPOSE
//   Multi-cycle controller that reuses a single 4-bit adder slice to add or subtract
//   NIBBLES*4-bit operands, one nibble per clock, LSB nibble first.
//   Holds the ripple carry in a register between slices.
//   Sits between a requester (start/ready/done handshake) and the Add4 datapath.
//   Trades NIBBLES cycles of latency for one adder instance instead of NIBBLES.
// PARAMETERS
//   NIBBLES   4   operand width in nibbles (W = 4*NIBBLES bits); legal range 2..16
// PORTS
//   clk     in   1     single clock; all state updates on rising edge
//   rst_n   in   1     asynchronous, active-low reset
//   start   in   1     request; accepted only when ready=1
//   sub     in   1     0: a+b+cin, 1: a-b (b inverted, cin forced 1); sampled with start
//   a       in   W     operand A; sampled on the accepting edge
//   b       in   W     operand B; sampled on the accepting edge
//   cin     in   1     carry-in for add; ignored when sub=1
//   ready   out  1     high only in IDLE
//   busy    out  1     high in RUN and DONE
//   done    out  1     one-cycle pulse; sum/cout/ovf are valid while it is high
//   sum     out  W     registered result; holds until the next DONE entry
//   cout    out  1     carry out of MSB nibble; for sub, 1 means no borrow
//   ovf     out  1     two's-complement signed overflow of the W-bit result
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0.
//     Internal regs (opA, opB, carry, idx, partial result) are cleared.
//     Reset during RUN or DONE aborts the operation: no done pulse, outputs read 0.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE, edge with start=1:
//     opA<=a; opB<=(sub ? ~b : b); carry<=(sub ? 1 : cin); idx<=0; -> RUN.
//     Record sign bits a[W-1] and b'[W-1] for ovf.
//   RUN, every cycle:
//     Drive slice with opA[3:0], opB[3:0], carry.
//     At the edge: shift the slice sum into the partial result from the top;
//       shift opA/opB right by 4; carry<=slice cout; idx<=idx+1.
//     When idx==NIBBLES-1 at the edge: -> DONE.
//     On that edge: sum<=final partial result, cout<=slice cout,
//       ovf<=(signA==signB) && (sum[W-1]!=signA).
//   DONE: done=1 for exactly one cycle; -> IDLE unconditionally.
//   Latency: done is high in the cycle after the NIBBLES-th edge following the accepting
//     edge (NIBBLES cycles). Max throughput is one op per NIBBLES+2 cycles.
//   start while busy=1 (RUN or DONE) is ignored and not queued.
//     start held high continuously gives back-to-back ops, one per NIBBLES+2 cycles.
//   Input changes after acceptance have no effect on the operation in flight.
//   idx width is clog2(NIBBLES); idx never wraps, because the FSM leaves RUN at NIBBLES-1.
//   All arithmetic is modulo 2^W. Carry out of the MSB nibble goes only to cout.
// STRUCTURE
//   Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
//     ST_3 is illegal and decodes to IDLE.
//   Sub-module: one Add4 instance as the nibble slice (existing datapath, unmodified).
//   This block adds only the FSM, idx counter, carry flop, operand/result shift registers
//     and the output registers.
// TESTING   (NIBBLES=4, W=16)
//   1. Reset: rst_n=0 mid-clock -> immediately ready=1, busy=0, done=0, sum=0, cout=0, ovf=0.
//   2. a=16'h00FF, b=16'h0001, sub=0, cin=0 -> done 4 cycles after accept;
//      sum=16'h0100, cout=0, ovf=0.
//   3. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0.
//      a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
//   4. sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0, ovf=0.
//      sub=1, a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
//   5. start held high for 20 cycles, operands changed every cycle -> exactly 3 done pulses,
//      6 cycles apart; each result matches the operands sampled at its own accept edge.
//   6. rst_n pulsed low 2 cycles into RUN -> no done pulse, sum=0;
//      next start after reset gives a correct result.

Source files
------------

// File: rtl/add4_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// add4_sequencer_pkg
//   Shared definitions for the nibble-serial add/subtract sequencer.
//   - state_t      : FSM state encoding (IDLE/RUN/DONE, code 3 unused)
//   - decode_state : maps the unused code onto IDLE so a corrupted state
//                    register recovers instead of locking up
// ---------------------------------------------------------------------------
package add4_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_3    = 2'd3
    } state_t;

    function automatic state_t decode_state(input state_t s);
        return (s == ST_3) ? ST_IDLE : s;
    endfunction

endpackage

// File: rtl/add4_sequencer_add4.sv
// ---------------------------------------------------------------------------
// add4_sequencer_add4
//   Plain 4-bit ripple adder slice, purely combinational.
//   Ports:
//     a, b  in  4  addends
//     cin   in  1  carry in
//     s     out 4  sum
//     cout  out 1  carry out of bit 3
// ---------------------------------------------------------------------------
module add4_sequencer_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign s     = total[3:0];
    assign cout  = total[4];

endmodule

// File: rtl/add4_sequencer.sv
// ---------------------------------------------------------------------------
// add4_sequencer
//   Adds or subtracts two 4*NIBBLES-bit operands using a single 4-bit adder
//   slice, one nibble per clock, least significant nibble first. The ripple
//   carry is held in a flop between slices.
//   Parameters:
//     NIBBLES  operand width in nibbles (W = 4*NIBBLES), legal 2..16
//   Ports:
//     clk    in   1  rising-edge clock
//     rst_n  in   1  asynchronous active-low reset
//     start  in   1  request, accepted only while ready=1
//     sub    in   1  0: a+b+cin, 1: a-b ; sampled with start
//     a, b   in   W  operands, sampled on the accepting edge
//     cin    in   1  carry-in for add, ignored for subtract
//     ready  out  1  idle and able to accept
//     busy   out  1  operation running or completing
//     done   out  1  one-cycle pulse, result valid while high
//     sum    out  W  registered result, held until the next completion
//     cout   out  1  carry out of the MSB nibble (subtract: 1 = no borrow)
//     ovf    out  1  two's-complement overflow of the W-bit result
// ---------------------------------------------------------------------------
module add4_sequencer
    import add4_sequencer_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           state_q;
    state_t           state_d;
    state_t           cur;
    logic             accept;
    logic             last;

    logic [W-1:0]     opa_q;
    logic [W-1:0]     opb_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     part_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0]       slice_s;
    logic             slice_co;
    logic [W-1:0]     part_next;

    add4_sequencer_add4 u_slice (
        .a    (opa_q[3:0]),
        .b    (opb_q[3:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    // Each slice result enters from the top; after NIBBLES shifts the first
    // (least significant) nibble has reached bit 0.
    assign part_next = {slice_s, part_q[W-1:4]};

    assign cur = decode_state(state_q);

    always_comb begin
        state_d = ST_IDLE;
        accept  = 1'b0;
        last    = 1'b0;
        case (cur)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx_q == IDX_LAST) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            part_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Subtract is a + ~b + 1; the sign of the inverted b is what
                // the overflow rule compares against.
                opa_q    <= a;
                opb_q    <= sub ? ~b : b;
                carry_q  <= sub ? 1'b1 : cin;
                idx_q    <= '0;
                part_q   <= '0;
                sign_a_q <= a[W-1];
                sign_b_q <= sub ? ~b[W-1] : b[W-1];
            end else if (cur == ST_RUN) begin
                part_q  <= part_next;
                opa_q   <= {4'b0000, opa_q[W-1:4]};
                opb_q   <= {4'b0000, opb_q[W-1:4]};
                carry_q <= slice_co;
                if (last) begin
                    // idx holds at its last value rather than wrapping.
                    sum_q  <= part_next;
                    cout_q <= slice_co;
                    ovf_q  <= (sign_a_q == sign_b_q) && (slice_s[3] != sign_a_q);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign ready = (cur == ST_IDLE);
    assign busy  = (cur == ST_RUN) || (cur == ST_DONE);
    assign done  = (cur == ST_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_add4_sequencer.sv
// ---------------------------------------------------------------------------
// tb_add4_sequencer
//   Directed bench for add4_sequencer with NIBBLES=4 (W=16).
// ---------------------------------------------------------------------------
module tb_add4_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int vectors;
    int miscompares;

    add4_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result as a whole-word add: {ovf, cout, sum}.
    function automatic logic [17:0] model_op(input logic [15:0] ma, input logic [15:0] mb,
                                             input logic msub, input logic mcin);
        logic [15:0] bb;
        logic [16:0] t;
        logic        ov;
        bb = msub ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub ? 1'b1 : mcin)};
        ov = (ma[15] == bb[15]) && (t[15] != ma[15]);
        return {ov, t[16], t[15:0]};
    endfunction

    // One complete operation with hand-computed expectations; operands are
    // scrambled right after acceptance to show they are not re-sampled.
    task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic isub, input logic icin,
                          input logic [15:0] esum, input logic ecout, input logic eovf);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia; b = ~ib; sub = ~isub; cin = ~icin;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= NIBBLES; k++) begin
            @(posedge clk);
            #1;
            if (k < NIBBLES) chk({tag, ".early_done"}, 32'(done), 32'd0);
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".sum"},  32'(sum),  32'(esum));
        chk({tag, ".cout"}, 32'(cout), 32'(ecout));
        chk({tag, ".ovf"},  32'(ovf),  32'(eovf));
        @(posedge clk);
        #1;
        chk({tag, ".ready_after"}, 32'(ready), 32'd1);
        chk({tag, ".sum_hold"},    32'(sum),   32'(esum));
    endtask

    initial begin
        int          mcnt;
        int          dcnt;
        int          dcyc[$];
        logic [17:0] exp_r;
        logic [15:0] ta;
        logic [15:0] tb;

        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset values before any clock edge
        #2;
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.done",  32'(done),  32'd0);
        chk("rst.sum",   32'(sum),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain adds, carry-out, signed overflow
        run_op("add_ff",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_cin",  16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
        // Subtraction, borrow and overflow
        run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_cin",  16'h0010, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset mid-clock clears held result immediately
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.ready", 32'(ready), 32'd1);
        chk("rst_mid.sum",   32'(sum),   32'd0);
        chk("rst_mid.cout",  32'(cout),  32'd0);
        chk("rst_mid.ovf",   32'(ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // start held high for 20 edges with operands changing every cycle
        mcnt = 0;
        dcnt = 0;
        exp_r = '0;
        for (int i = 0; i < 28; i++) begin
            ta = 16'(i * 16'h3A7D + 16'h7FF0);
            tb = 16'(i * 16'h1C35) ^ 16'h8421;
            a = ta; b = tb; sub = i[0]; cin = i[1];
            start = (i < 20);
            @(posedge clk);
            if (mcnt == 0) begin
                if (start) begin
                    exp_r = model_op(ta, tb, i[0], i[1]);
                    mcnt  = 1;
                end
            end else if (mcnt == NIBBLES + 1) begin
                mcnt = 0;
            end else begin
                mcnt++;
            end
            #1;
            chk("burst.ready", 32'(ready), 32'(mcnt == 0));
            chk("burst.done",  32'(done),  32'(mcnt == NIBBLES + 1));
            if (mcnt == NIBBLES + 1) begin
                chk("burst.sum",  32'(sum),  32'(exp_r[15:0]));
                chk("burst.cout", 32'(cout), 32'(exp_r[16]));
                chk("burst.ovf",  32'(ovf),  32'(exp_r[17]));
                if (i < 20) dcnt++;
                dcyc.push_back(i);
            end
        end
        start = 1'b0;
        chk("burst.done_count", 32'(dcnt), 32'd3);
        chk("burst.total_ops",  32'(dcyc.size()), 32'd4);
        if (dcyc.size() >= 3) begin
            chk("burst.gap1", 32'(dcyc[1] - dcyc[0]), 32'(NIBBLES + 2));
            chk("burst.gap2", 32'(dcyc[2] - dcyc[1]), 32'(NIBBLES + 2));
        end

        // Reset two cycles into RUN aborts the operation
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort.ready", 32'(ready), 32'd1);
        chk("abort.busy",  32'(busy),  32'd0);
        chk("abort.done",  32'(done),  32'd0);
        chk("abort.sum",   32'(sum),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("abort.no_done", 32'(dcnt), 32'd0);
        chk("abort.sum_hold", 32'(sum), 32'd0);
        run_op("after_abort", 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
